// File: rtl/draw_pkg.sv
// Shared drawing-pipeline constants and the pixel record carried through the plot buffer.
package draw_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned COORD_W   = 10;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b000;

  // One buffered framebuffer write: address in the upper bits, colour in the lower bits.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   color;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with full/empty flags and a combinational head output.
module pixel_fifo import draw_pkg::*; #(
  parameter int unsigned WIDTH = PIXEL_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IdxW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign head_data = mem_q[rd_ptr_q[IdxW-1:0]];

  // Pointer update; reset empties the buffer regardless of pending push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) begin
      mem_q[wr_ptr_q[IdxW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/plot_receiver.sv
// Accepts pixels from the sprite drawer, drops off-screen/transparent ones, buffers the rest
// and hands them to the framebuffer under a write/grant handshake.
module plot_receiver import draw_pkg::*; #(
  parameter int unsigned        SCREEN_W    = draw_pkg::SCREEN_W,
  parameter int unsigned        SCREEN_H    = draw_pkg::SCREEN_H,
  parameter int unsigned        FIFO_DEPTH  = 4,
  parameter logic [COLOR_W-1:0] TRANSPARENT = draw_pkg::TRANSPARENT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [COLOR_W-1:0]   in_color,
  input  logic                 in_plot,
  output logic                 in_ready,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  input  logic                 fb_grant,
  output logic                 overflow,
  output logic [15:0]          written_count,
  output logic [7:0]           clipped_count
);

  logic                 full, empty;
  logic                 accept, keep, clip, lost, commit;
  logic                 in_range;
  logic [FB_ADDR_W-1:0] addr_calc;
  pixel_t               push_pix, head_pix;
  logic                 overflow_q;
  logic [15:0]          written_q;
  logic [7:0]           clipped_q;

  // Full-width multiply so large rows cannot truncate before the add.
  assign addr_calc = FB_ADDR_W'(in_y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(in_x);
  assign in_range  = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);

  assign in_ready = !full;
  assign accept   = in_plot && in_ready;
  assign keep     = accept && in_range && (in_color != TRANSPARENT);
  assign clip     = accept && !keep;
  assign lost     = in_plot && !in_ready;
  assign commit   = fb_we && fb_grant;

  assign push_pix.addr  = addr_calc;
  assign push_pix.color = in_color;

  pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (keep),
    .push_data (push_pix),
    .pop       (commit),
    .head_data (head_pix),
    .full      (full),
    .empty     (empty)
  );

  // Framebuffer request follows the buffer head; zeroed while nothing is queued.
  always_comb begin
    fb_we   = !empty;
    fb_addr = '0;
    fb_data = '0;
    if (!empty) begin
      fb_addr = head_pix.addr;
      fb_data = head_pix.color;
    end
  end

  // Sticky overflow and the written/clipped statistics.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      written_q  <= '0;
      clipped_q  <= '0;
    end else begin
      if (lost)                        overflow_q <= 1'b1;
      if (commit)                      written_q  <= written_q + 16'd1;
      if (clip && (clipped_q != 8'hff)) clipped_q  <= clipped_q + 8'd1;
    end
  end

  assign overflow      = overflow_q;
  assign written_count = written_q;
  assign clipped_count = clipped_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Directed bench for plot_receiver with hand-computed expected values.
module tb_plot_receiver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  in_x, in_y;
  logic [2:0]  in_color;
  logic        in_plot;
  logic        in_ready;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_grant;
  logic        overflow;
  logic [15:0] written_count;
  logic [7:0]  clipped_count;

  int n_vec = 0;
  int n_miscompare = 0;

  always #5 clk = ~clk;

  plot_receiver dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_color      (in_color),
    .in_plot       (in_plot),
    .in_ready      (in_ready),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .fb_grant      (fb_grant),
    .overflow      (overflow),
    .written_count (written_count),
    .clipped_count (clipped_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int c, input logic plot);
    in_x     = 10'(x);
    in_y     = 10'(y);
    in_color = 3'(c);
    in_plot  = plot;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  logic saw_we;

  initial begin
    reset_n  = 1'b0;
    fb_grant = 1'b0;
    drive(0, 0, 0, 1'b0);
    #1;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_written", written_count, 0);
    check("rst_clipped", clipped_count, 0);

    // Single pixel (5,2,5): one-cycle latency, address 2*320+5
    fb_grant = 1'b1;
    drive(5, 2, 5, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("single_we", fb_we, 1);
    check("single_addr", fb_addr, 645);
    check("single_data", fb_data, 5);
    check("single_written_pre", written_count, 0);
    step();
    check("single_written", written_count, 1);
    check("single_we_after", fb_we, 0);
    check("single_addr_empty", fb_addr, 0);

    // Clip filter: only (319,239) survives
    fb_grant = 1'b0;
    drive(319, 239, 1, 1'b1); step();
    drive(320, 0, 1, 1'b1);   step();
    drive(0, 240, 1, 1'b1);   step();
    drive(3, 3, 0, 1'b1);     step();
    drive(0, 0, 0, 1'b0);
    check("clip_count", clipped_count, 3);
    check("clip_we", fb_we, 1);
    check("clip_addr", fb_addr, 76799);
    check("clip_data", fb_data, 1);
    fb_grant = 1'b1;
    step();
    check("clip_written", written_count, 2);
    check("clip_empty", fb_we, 0);

    // Backpressure: 6 pixels with no grant, depth 4
    fb_grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(10 + i, 1, 2, 1'b1);
      step();
      check($sformatf("bp_ready_%0d", i), in_ready, (i < 3) ? 1 : 0);
      check($sformatf("bp_ovf_%0d", i), overflow, (i >= 4) ? 1 : 0);
    end
    drive(0, 0, 0, 1'b0);
    step();
    check("bp_hold_we", fb_we, 1);
    check("bp_hold_addr", fb_addr, 330);
    check("bp_hold_written", written_count, 2);
    fb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_addr_%0d", i), fb_addr, 330 + i);
      check($sformatf("bp_drain_data_%0d", i), fb_data, 2);
      step();
    end
    check("bp_drained_we", fb_we, 0);
    check("bp_written", written_count, 6);
    check("bp_ovf_sticky", overflow, 1);
    check("bp_clipped", clipped_count, 3);

    // Streaming: simultaneous push/pop every cycle
    do_reset();
    check("stream_rst_ovf", overflow, 0);
    fb_grant = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(i, 100, (i % 7) + 1, 1'b1);
      step();
      check($sformatf("stream_ready_%0d", i), in_ready, 1);
      check($sformatf("stream_addr_%0d", i), fb_addr, 32000 + i);
      check($sformatf("stream_data_%0d", i), fb_data, (i % 7) + 1);
    end
    drive(0, 0, 0, 1'b0);
    step();
    check("stream_written", written_count, 32);
    check("stream_we_off", fb_we, 0);
    check("stream_ovf", overflow, 0);

    // Reset with three entries queued and traffic on the inputs
    fb_grant = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(i, 0, 7, 1'b1);
      step();
    end
    check("mid_we", fb_we, 1);
    check("mid_addr", fb_addr, 1);
    check("mid_written", written_count, 32);
    reset_n  = 1'b0;
    fb_grant = 1'b1;
    drive(9, 9, 6, 1'b1);
    step();
    reset_n  = 1'b1;
    fb_grant = 1'b0;
    drive(0, 0, 0, 1'b0);
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_addr", fb_addr, 0);
    check("mid_rst_written", written_count, 0);
    check("mid_rst_clipped", clipped_count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ready", in_ready, 1);
    step();
    check("mid_rst_ignored_plot", fb_we, 0);

    // 300 transparent pixels: clip count saturates, nothing written
    fb_grant = 1'b1;
    saw_we   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(7, 7, 0, 1'b1);
      step();
      if (fb_we) saw_we = 1'b1;
      if (i == 99)  check("sat_clipped_100", clipped_count, 100);
      if (i == 254) check("sat_clipped_255", clipped_count, 255);
    end
    drive(0, 0, 0, 1'b0);
    check("sat_clipped_end", clipped_count, 255);
    check("sat_no_we", saw_we, 0);
    check("sat_written", written_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
